mul_unit: RTL and testbench

// - Iterative multi-cycle multiply / multiply-accumulate engine for the multicycle ARM core.
// - Replaces the single-cycle long-multiply path in the ALU.
// - Executes MUL, MLA, UMULL, UMLAL, SMULL and SMLAL over WIDTH/BPC cycles, using a start/busy/done handshake.
// - The controller stalls in its multiply state until done; result_lo and result_hi feed the register-file write ports (wd3, wd4).

---
 rtl/mul_pkg.sv | 19 +
 rtl/mul_step.sv | 26 ++
 rtl/mul_unit.sv | 148 ++++++++++++++
 tb/tb_mul_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared opcodes and FSM state type for the iterative multiplier
package mul_pkg;

    // op = {long, signed, accumulate}
    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MLA   = 3'b001;
    localparam logic [2:0] OP_UMULL = 3'b100;
    localparam logic [2:0] OP_UMLAL = 3'b101;
    localparam logic [2:0] OP_SMULL = 3'b110;
    localparam logic [2:0] OP_SMLAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one shift-add iteration: sum = prod + ((bits * a) << pos)
//
// Ports:
//   prod  in   2*WIDTH         running product
//   a     in   WIDTH           multiplicand magnitude
//   bits  in   BPC             multiplier bits retired this iteration
//   pos   in   clog2(2*WIDTH)  bit position of those multiplier bits
//   sum   out  2*WIDTH         updated running product
module mul_step #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic [2*WIDTH-1:0]         prod,
    input  logic [WIDTH-1:0]           a,
    input  logic [BPC-1:0]             bits,
    input  logic [$clog2(2*WIDTH)-1:0] pos,
    output logic [2*WIDTH-1:0]         sum
);

    logic [2*WIDTH-1:0] part;

    // bits*a needs at most WIDTH+BPC bits, so the 2*WIDTH product never truncates.
    assign part = ({{(2*WIDTH-BPC){1'b0}}, bits} * {{WIDTH{1'b0}}, a}) << pos;
    assign sum  = prod + part;

endmodule

// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - iterative MUL/MLA/UMULL/UMLAL/SMULL/SMLAL engine with start/busy/done handshake
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   start, flush         launch request (IDLE/DONE only); synchronous cancel
//   op                   {long, signed, accumulate}
//   a, b                 multiplicand, multiplier
//   acc_hi, acc_lo       accumulate words
//   busy, done           high in RUN/FIX; one-cycle completion pulse
//   result_lo, result_hi result words (result_hi = 0 for short ops)
//   flag_n, flag_z       sign and zero of the result
module mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int STEPS = WIDTH / BPC;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int PW    = $clog2(2 * WIDTH);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [PW-1:0]        pos;
    logic                 long_q;
    logic                 accum_q;
    logic                 neg;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     acc_hi_q;
    logic [WIDTH-1:0]     acc_lo_q;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   prod_nxt;

    logic                 signed_op;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   p_fix;
    logic [2*WIDTH-1:0]   r_long;
    logic [WIDTH-1:0]     r_short;

    // Short signed ops run unsigned: the low word is the same either way.
    assign signed_op = op[2] & op[1];
    // -x of the most-negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag = (signed_op && b[WIDTH-1]) ? -b : b;

    mul_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
        .prod (prod),
        .a    (a_q),
        .bits (b_q[BPC-1:0]),
        .pos  (pos),
        .sum  (prod_nxt)
    );

    always_comb begin
        p_fix   = neg ? -prod : prod;
        r_long  = p_fix + (accum_q ? {acc_hi_q, acc_lo_q} : {(2*WIDTH){1'b0}});
        r_short = p_fix[WIDTH-1:0] + (accum_q ? acc_lo_q : {WIDTH{1'b0}});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            pos       <= '0;
            long_q    <= 1'b0;
            accum_q   <= 1'b0;
            neg       <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            prod      <= '0;
            result_lo <= '0;
            result_hi <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        long_q   <= op[2];
                        accum_q  <= op[0];
                        neg      <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        a_q      <= a_mag;
                        b_q      <= b_mag;
                        acc_hi_q <= acc_hi;
                        acc_lo_q <= acc_lo;
                        prod     <= '0;
                        pos      <= '0;
                        cnt      <= CW'(STEPS);
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    prod <= prod_nxt;
                    b_q  <= b_q >> BPC;
                    pos  <= pos + PW'(BPC);
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state <= DONE;
                    if (long_q) begin
                        result_lo <= r_long[WIDTH-1:0];
                        result_hi <= r_long[2*WIDTH-1:WIDTH];
                        flag_n    <= r_long[2*WIDTH-1];
                        flag_z    <= (r_long == '0);
                    end else begin
                        result_lo <= r_short;
                        result_hi <= '0;
                        flag_n    <= r_short[WIDTH-1];
                        flag_z    <= (r_short == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mul_unit.sv
// tb/tb_mul_unit.sv - directed and reference-model checks of mul_unit at BPC=1 and BPC=4
module tb_mul_unit;
    import mul_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start1 = 1'b0;
    logic        start4 = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0, b = '0, acc_hi = '0, acc_lo = '0;

    logic        busy1, done1, n1, z1;
    logic [31:0] lo1, hi1;
    logic        busy4, done4, n4, z4;
    logic [31:0] lo4, hi4;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mul_unit #(.WIDTH(32), .BPC(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .flush(flush), .op(op),
        .a(a), .b(b), .acc_hi(acc_hi), .acc_lo(acc_lo),
        .busy(busy1), .done(done1), .result_lo(lo1), .result_hi(hi1),
        .flag_n(n1), .flag_z(z1)
    );

    mul_unit #(.WIDTH(32), .BPC(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .flush(flush), .op(op),
        .a(a), .b(b), .acc_hi(acc_hi), .acc_lo(acc_lo),
        .busy(busy4), .done(done4), .result_lo(lo4), .result_hi(hi4),
        .flag_n(n4), .flag_z(z4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drive operands at a negedge, hold start across one rising edge.
    task automatic launch(input logic sel4, input logic [2:0] o, input logic [31:0] aa, bb, ah, al);
        @(negedge clk);
        op = o; a = aa; b = bb; acc_hi = ah; acc_lo = al;
        if (sel4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    // Cycles counted from the start edge to the first negedge with done high.
    task automatic wait_done(input logic sel4, output int cyc);
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (sel4 ? done4 : done1) break;
        end
    endtask

    function automatic logic [65:0] model(input logic [2:0] o, input logic [31:0] x, y, ah, al);
        logic [63:0] p, r;
        if (o[2] && o[1]) p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        else              p = {32'd0, x} * {32'd0, y};
        if (o[2]) begin
            r = p + (o[0] ? {ah, al} : 64'd0);
            return {r[63], r == 64'd0, r};
        end
        r = {32'd0, p[31:0] + (o[0] ? al : 32'd0)};
        return {r[31], r[31:0] == 32'd0, r};
    endfunction

    initial begin
        int cyc;
        int dones;
        bit got;
        logic [2:0]  ops [6];
        logic [2:0]  ro;
        logic [31:0] ra, rb, rh, rl;
        logic [65:0] m;
        ops[0] = OP_MUL;   ops[1] = OP_MLA;   ops[2] = OP_UMULL;
        ops[3] = OP_UMLAL; ops[4] = OP_SMULL; ops[5] = OP_SMLAL;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl1", {busy1, done1, n1, z1}, 4'b0000);
        check("rst_res1", {hi1, lo1}, 64'd0);
        check("rst_ctrl4", {busy4, done4, n4, z4}, 4'b0000);
        check("rst_res4", {hi4, lo4}, 64'd0);
        reset = 1'b1;

        // UMULL max*max with exact latency
        launch(1'b0, OP_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0);
        check("busy_run", busy1, 1'b1);
        wait_done(1'b0, cyc);
        check("umull_lat", cyc, 34);
        check("umull_res", {hi1, lo1}, 64'hFFFFFFFE_00000001);
        check("umull_nz", {n1, z1}, 2'b10);
        check("busy_at_done", busy1, 1'b0);
        @(negedge clk);
        check("done_pulse", done1, 1'b0);

        // SMULL -2*3
        launch(1'b0, OP_SMULL, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0);
        wait_done(1'b0, cyc);
        check("smull_res", {hi1, lo1}, 64'hFFFFFFFF_FFFFFFFA);
        check("smull_nz", {n1, z1}, 2'b10);

        // SMULL most-negative squared
        launch(1'b0, OP_SMULL, 32'h80000000, 32'h80000000, 32'd0, 32'd0);
        wait_done(1'b0, cyc);
        check("smull_min", {hi1, lo1}, 64'h40000000_00000000);
        check("smull_min_nz", {n1, z1}, 2'b00);

        // MLA wrapping to zero
        launch(1'b0, OP_MLA, 32'd5, 32'd7, 32'h12345678, 32'hFFFFFFDD);
        wait_done(1'b0, cyc);
        check("mla_res", {hi1, lo1}, 64'd0);
        check("mla_nz", {n1, z1}, 2'b01);

        // UMLAL 64-bit wrap
        launch(1'b0, OP_UMLAL, 32'd2, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(1'b0, cyc);
        check("umlal_res", {hi1, lo1}, 64'h00000000_00000001);
        check("umlal_nz", {n1, z1}, 2'b00);

        // Start pulsed mid-run is ignored
        launch(1'b0, OP_MUL, 32'd6, 32'd7, 32'd0, 32'd0);
        cyc = 0; got = 0;
        while (cyc < 100 && !got) begin
            @(negedge clk);
            cyc++;
            start1 = (cyc == 5);
            if (cyc == 5) begin op = OP_UMULL; a = 32'd100; b = 32'd100; end
            if (done1) got = 1;
        end
        start1 = 1'b0;
        check("restart_lat", cyc, 34);
        check("restart_res", {hi1, lo1}, 64'd42);
        dones = 0;
        repeat (40) begin @(negedge clk); if (done1) dones++; end
        check("restart_single_done", dones, 0);

        // Flush mid-run: IDLE next cycle, no done, outputs kept
        launch(1'b0, OP_UMULL, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", busy1, 1'b0);
        dones = 0;
        repeat (40) begin @(negedge clk); if (done1) dones++; end
        check("flush_no_done", dones, 0);
        check("flush_keep_res", {hi1, lo1}, 64'd42);
        check("flush_keep_nz", {n1, z1}, 2'b00);

        // Flush and start together: flush wins
        @(negedge clk);
        flush = 1'b1; start1 = 1'b1;
        @(negedge clk);
        flush = 1'b0; start1 = 1'b0;
        check("flush_beats_start", {busy1, done1}, 2'b00);

        // Asynchronous reset mid-run, then a fresh op
        launch(1'b0, OP_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0);
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_ctrl", {busy1, done1, n1, z1}, 4'b0000);
        check("arst_res", {hi1, lo1}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        launch(1'b0, OP_SMLAL, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd10);
        wait_done(1'b0, cyc);
        check("post_rst_lat", cyc, 34);
        check("post_rst_res", {hi1, lo1}, 64'd4);

        // BPC=4: latency and back-to-back start in DONE
        launch(1'b1, OP_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0);
        wait_done(1'b1, cyc);
        check("b4_lat", cyc, 10);
        check("b4_res", {hi4, lo4}, 64'hFFFFFFFE_00000001);
        op = OP_SMULL; a = 32'hFFFFFFFE; b = 32'd3;
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        wait_done(1'b1, cyc);
        check("b2b_lat", cyc, 10);
        check("b2b_res", {hi4, lo4}, 64'hFFFFFFFF_FFFFFFFA);

        // BPC=4 random ops against the reference model
        for (int i = 0; i < 1000; i++) begin
            ro = ops[$urandom_range(0, 5)];
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            rh = $urandom;
            rl = $urandom;
            m  = model(ro, ra, rb, rh, rl);
            launch(1'b1, ro, ra, rb, rh, rl);
            wait_done(1'b1, cyc);
            check("rnd_lat", cyc, 10);
            check("rnd_res", {hi4, lo4}, m[63:0]);
            check("rnd_nz", {n4, z4}, m[65:64]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
